// File: rtl/path_replayer.sv
// path_replayer
//   Buffers the maze solver's popped direction stack (which arrives final move
//   first) and replays it start-to-goal as a valid/ready move stream, tracking
//   the rat's position and stopping on any step that would leave the grid.
//
// Handshake: a transfer happens on a cycle where valid && ready are both high
// at the rising clock edge. Once move_valid rises it stays high, with move_dir
// stable, until the move is taken (only reset can withdraw it).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   in_valid/in_ready/in_dir  solver direction entries (00 y-1, 01 x+1, 10 x-1, 11 y+1)
//   in_last                   marks the final entry of the path
//   nil                       zero-length path pulse (goal == start)
//   start_x/start_y           start cell, sampled on first entry or nil
//   move_valid/ready/dir      replayed move stream, forward order
//   pos_x/pos_y               position after the last accepted move
//   busy                      loading or playing
//   done                      replay finished, pos holds goal
//   err                       00 none, 01 overflow, 10 off-grid; sticky until clear
//   clear                     returns DONE/ERR to IDLE
module path_replayer #(
    parameter int DEPTH = 16,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_dir,
    input  logic         in_last,
    input  logic         nil,
    input  logic [W-1:0] start_x,
    input  logic [W-1:0] start_y,
    output logic         move_valid,
    input  logic         move_ready,
    output logic [1:0]   move_dir,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic         busy,
    output logic         done,
    output logic [1:0]   err,
    input  logic         clear
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [W-1:0]  COORD_MAX = {W{1'b1}};
    localparam logic [W-1:0]  COORD_ONE = W'(1);
    localparam logic [AW:0]   WP_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   WP_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] IDX_TWO   = AW'(2);

    localparam logic [1:0] DIR_UP    = 2'b00;  // y-1
    localparam logic [1:0] DIR_RIGHT = 2'b01;  // x+1
    localparam logic [1:0] DIR_LEFT  = 2'b10;  // x-1

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_GRID = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [AW:0]    wp_q, wp_d;
    logic [W-1:0]   pos_x_q, pos_x_d;
    logic [W-1:0]   pos_y_q, pos_y_d;
    logic           move_valid_q, move_valid_d;
    logic [1:0]     move_dir_q, move_dir_d;
    logic [1:0]     err_q, err_d;
    logic           in_ready_q, in_ready_d;
    logic [1:0]     buf_q [DEPTH];
    logic [1:0]     buf_d [DEPTH];

    logic           in_fire;
    logic           move_fire;
    logic [W-1:0]   step_x_pos;
    logic [W-1:0]   step_y_pos;
    logic [AW-1:0]  rd_idx;
    logic [1:0]     next_dir;

    // True when moving in direction d from (x,y) stays on the grid.
    function automatic logic step_ok(input logic [1:0] d, input logic [W-1:0] x,
                                     input logic [W-1:0] y);
        case (d)
            DIR_UP:    step_ok = (y != '0);
            DIR_RIGHT: step_ok = (x != COORD_MAX);
            DIR_LEFT:  step_ok = (x != '0);
            default:   step_ok = (y != COORD_MAX);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wp_q         <= '0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            move_valid_q <= 1'b0;
            move_dir_q   <= 2'b00;
            err_q        <= ERR_NONE;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            move_valid_q <= move_valid_d;
            move_dir_q   <= move_dir_d;
            err_q        <= err_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Path storage carries no reset; contents are only read below wp.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        move_valid_d = move_valid_q;
        move_dir_d   = move_dir_q;
        err_d        = err_q;
        buf_d        = buf_q;

        in_fire   = in_valid && in_ready_q;
        move_fire = move_valid_q && move_ready;

        // Position after the currently offered move is taken.
        step_x_pos = pos_x_q;
        step_y_pos = pos_y_q;
        case (move_dir_q)
            DIR_UP:    step_y_pos = pos_y_q - COORD_ONE;
            DIR_RIGHT: step_x_pos = pos_x_q + COORD_ONE;
            DIR_LEFT:  step_x_pos = pos_x_q - COORD_ONE;
            default:   step_y_pos = pos_y_q + COORD_ONE;
        endcase

        // Entry that follows the offered one (buf[wp-2]).
        rd_idx   = wp_q[AW-1:0] - IDX_TWO;
        next_dir = buf_q[rd_idx];

        case (state_q)
            S_IDLE: begin
                if (nil) begin
                    pos_x_d = start_x;
                    pos_y_d = start_y;
                    state_d = S_DONE;
                end else if (in_fire) begin
                    pos_x_d  = start_x;
                    pos_y_d  = start_y;
                    buf_d[0] = in_dir;
                    wp_d     = WP_ONE;
                    if (!in_last) begin
                        state_d = S_LOAD;
                    end else if (step_ok(in_dir, start_x, start_y)) begin
                        state_d      = S_PLAY;
                        move_valid_d = 1'b1;
                        move_dir_d   = in_dir;
                    end else begin
                        state_d = S_ERR;
                        err_d   = ERR_GRID;
                    end
                end
            end

            S_LOAD: begin
                if (in_fire) begin
                    if (wp_q == WP_FULL) begin
                        // No room: the entry is swallowed and the path abandoned.
                        state_d = S_ERR;
                        err_d   = ERR_OVF;
                    end else begin
                        buf_d[wp_q[AW-1:0]] = in_dir;
                        wp_d                = wp_q + WP_ONE;
                        if (in_last) begin
                            // The entry just received is the first move out.
                            if (step_ok(in_dir, pos_x_q, pos_y_q)) begin
                                state_d      = S_PLAY;
                                move_valid_d = 1'b1;
                                move_dir_d   = in_dir;
                            end else begin
                                state_d = S_ERR;
                                err_d   = ERR_GRID;
                            end
                        end
                    end
                end
            end

            S_PLAY: begin
                if (move_fire) begin
                    pos_x_d = step_x_pos;
                    pos_y_d = step_y_pos;
                    wp_d    = wp_q - WP_ONE;
                    if (wp_q == WP_ONE) begin
                        state_d      = S_DONE;
                        move_valid_d = 1'b0;
                    end else if (step_ok(next_dir, step_x_pos, step_y_pos)) begin
                        move_dir_d = next_dir;
                    end else begin
                        // Checked before offering, so an off-grid move never appears.
                        state_d      = S_ERR;
                        err_d        = ERR_GRID;
                        move_valid_d = 1'b0;
                    end
                end
            end

            S_DONE: begin
                if (clear) begin
                    state_d = S_IDLE;
                    wp_d    = '0;
                end
            end

            S_ERR: begin
                move_valid_d = 1'b0;
                if (clear) begin
                    state_d = S_IDLE;
                    wp_d    = '0;
                    err_d   = ERR_NONE;
                end
            end

            default: begin
                state_d      = S_IDLE;
                wp_d         = '0;
                move_valid_d = 1'b0;
            end
        endcase

        // Registered so in_ready reads 0 while reset is held.
        in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = in_ready_q;
        move_valid = move_valid_q;
        move_dir   = move_dir_q;
        pos_x      = pos_x_q;
        pos_y      = pos_y_q;
        busy       = (state_q == S_LOAD) || (state_q == S_PLAY);
        done       = (state_q == S_DONE);
        err        = err_q;
    end

endmodule

// File: tb/tb_path_replayer.sv
module tb_path_replayer;

  localparam int DEPTH = 16;
  localparam int W     = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_dir;
  logic         in_last;
  logic         nil;
  logic [W-1:0] start_x;
  logic [W-1:0] start_y;
  logic         move_valid;
  logic         move_ready;
  logic [1:0]   move_dir;
  logic [W-1:0] pos_x;
  logic [W-1:0] pos_y;
  logic         busy;
  logic         done;
  logic [1:0]   err;
  logic         clear;

  int checks = 0;
  int errors = 0;

  logic [1:0]   exp_q[$];
  logic [1:0]   sdirs[$];
  logic [W-1:0] mx, my;

  path_replayer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dir     (in_dir),
    .in_last    (in_last),
    .nil        (nil),
    .start_x    (start_x),
    .start_y    (start_y),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_dir   (move_dir),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .clear      (clear)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer n entries from sdirs; returns at the negedge after the last transfer.
  task automatic send_path(input int n, input logic [W-1:0] sx, input logic [W-1:0] sy,
                           input logic with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("in_ready_offer", in_ready, 1);
      in_valid = 1'b1;
      in_dir   = sdirs[i];
      in_last  = with_last && (i == n - 1);
      start_x  = sx;
      start_y  = sy;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume moves with a move_ready pattern (bit k = cycle k), comparing
  // against exp_q and a position model started at (sx,sy).
  task automatic drain(input logic [15:0] pat, input int n_exp, input int done_k_exp,
                       input logic [W-1:0] sx, input logic [W-1:0] sy);
    int moves;
    int done_k;
    logic have_stall;
    logic [1:0] stall_dir;
    logic [1:0] d;
    mx = sx;
    my = sy;
    moves = 0;
    done_k = -1;
    have_stall = 1'b0;
    stall_dir = 2'b00;
    for (int k = 0; k < 40; k++) begin
      chk("pos_x", pos_x, mx);
      chk("pos_y", pos_y, my);
      if (done) begin
        done_k = k;
        break;
      end
      move_ready = (k < 16) ? pat[k] : 1'b1;
      if (move_valid) begin
        if (have_stall) chk("stall_dir_stable", move_dir, stall_dir);
        chk("move_within_count", moves < n_exp, 1);
        if (exp_q.size() > 0) begin
          d = exp_q[0];
          chk("move_dir", move_dir, d);
          if (move_ready) begin
            case (d)
              2'b00: my = my - 1'b1;
              2'b01: mx = mx + 1'b1;
              2'b10: mx = mx - 1'b1;
              default: my = my + 1'b1;
            endcase
            void'(exp_q.pop_front());
          end
        end
        if (move_ready) begin
          moves++;
          have_stall = 1'b0;
        end else begin
          have_stall = 1'b1;
          stall_dir = move_dir;
        end
      end
      @(negedge clk);
    end
    move_ready = 1'b0;
    chk("done_after_path", done, 1);
    chk("move_count", moves, n_exp);
    chk("done_cycle", done_k, done_k_exp);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_err", err, 0);
    chk("clear_in_ready", in_ready, 1);
    chk("clear_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_dir = 2'b00;
    in_last = 1'b0;
    nil = 1'b0;
    start_x = '0;
    start_y = '0;
    move_ready = 1'b0;
    clear = 1'b0;

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pos_x", pos_x, 0);
    chk("rst_pos_y", pos_y, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // 3-move path from (2,2), move_ready held high
    sdirs = '{2'b01, 2'b11, 2'b01};
    send_path(3, 4'd2, 4'd2, 1'b1);
    chk("play_busy", busy, 1);
    chk("play_in_ready", in_ready, 0);
    exp_q = '{2'b01, 2'b11, 2'b01};
    drain(16'hFFFF, 3, 3, 4'd2, 4'd2);
    chk("t1_final_x", pos_x, 4);
    chk("t1_final_y", pos_y, 3);
    do_clear();

    // same path, move_ready 1-0-0-1-1
    send_path(3, 4'd2, 4'd2, 1'b1);
    exp_q = '{2'b01, 2'b11, 2'b01};
    drain(16'h0019, 3, 5, 4'd2, 4'd2);
    chk("t2_final_x", pos_x, 4);
    chk("t2_final_y", pos_y, 3);
    do_clear();

    // nil pulse beats a simultaneous entry
    @(negedge clk);
    nil = 1'b1;
    in_valid = 1'b1;
    in_dir = 2'b00;
    start_x = 4'd5;
    start_y = 4'd7;
    @(negedge clk);
    nil = 1'b0;
    in_valid = 1'b0;
    chk("nil_done", done, 1);
    chk("nil_pos_x", pos_x, 5);
    chk("nil_pos_y", pos_y, 7);
    chk("nil_move_valid", move_valid, 0);
    @(negedge clk);
    chk("nil_move_valid_hold", move_valid, 0);
    chk("nil_done_hold", done, 1);
    do_clear();

    // overflow: 16 entries without last, then a 17th
    sdirs = {};
    for (int i = 0; i < DEPTH + 1; i++) sdirs.push_back(2'($urandom_range(0, 3)));
    send_path(DEPTH + 1, 4'd3, 4'd3, 1'b0);
    chk("ovf_err", err, 1);
    chk("ovf_move_valid", move_valid, 0);
    chk("ovf_in_ready", in_ready, 0);
    chk("ovf_busy", busy, 0);
    @(negedge clk);
    chk("ovf_err_sticky", err, 1);
    chk("ovf_move_valid_hold", move_valid, 0);
    do_clear();

    // off-grid first move: x-1 at x=0
    sdirs = '{2'b10};
    send_path(1, 4'd0, 4'd1, 1'b1);
    chk("og1_move_valid", move_valid, 0);
    chk("og1_err", err, 2);
    chk("og1_pos_x", pos_x, 0);
    chk("og1_pos_y", pos_y, 1);
    do_clear();

    // off-grid first move: y+1 at y=15
    sdirs = '{2'b11};
    send_path(1, 4'd15, 4'd15, 1'b1);
    chk("og2_move_valid", move_valid, 0);
    chk("og2_err", err, 2);
    chk("og2_pos_x", pos_x, 15);
    chk("og2_pos_y", pos_y, 15);
    do_clear();

    // off-grid second move: (14,0) x+1 legal, then x+1 at x=15
    sdirs = '{2'b01, 2'b01};
    send_path(2, 4'd14, 4'd0, 1'b1);
    chk("og3_move_valid", move_valid, 1);
    chk("og3_move_dir", move_dir, 1);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    chk("og3_move_valid_drop", move_valid, 0);
    chk("og3_err", err, 2);
    chk("og3_pos_x", pos_x, 15);
    chk("og3_pos_y", pos_y, 0);
    do_clear();

    // reset during replay after one move
    sdirs = '{2'b01, 2'b11, 2'b01};
    send_path(3, 4'd2, 4'd2, 1'b1);
    move_ready = 1'b1;
    @(negedge clk);
    chk("mid_pos_x", pos_x, 3);
    chk("mid_pos_y", pos_y, 2);
    rst = 1'b1;
    #1;
    chk("arst_pos_x", pos_x, 0);
    chk("arst_pos_y", pos_y, 0);
    chk("arst_move_valid", move_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_err", err, 0);
    move_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    sdirs = '{2'b00};
    send_path(1, 4'd3, 4'd4, 1'b1);
    exp_q = '{2'b00};
    drain(16'hFFFF, 1, 1, 4'd3, 4'd4);
    chk("post_rst_final_x", pos_x, 3);
    chk("post_rst_final_y", pos_y, 3);
    do_clear();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_replayer.md
Name: path_replayer

Overview:
- Downstream of the maze-solver controller; consumes its direction stack after the solve completes.
- The solver pops its stack one entry per transfer, so the path arrives final move first. This block buffers the entries LIFO and replays them in forward order (start to goal) as a valid/ready move stream.
- While replaying it tracks the rat's (x,y) position and flags any step that would leave the grid.

Parameters:
DEPTH, 16, path buffer capacity in moves (power of 2, >=2)
W, 4, coordinate width; grid is 2^W x 2^W, cells 0..2^W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  direction entry offered by solver
in_ready  out  1  block accepts entry this cycle
in_dir  in  2  popped direction code
in_last  in  1  qualifies final entry of path (bottom of stack)
nil  in  1  one-cycle pulse: zero-length path (solver finished at start cell)
start_x  in  W  start column, sampled on first accepted entry or nil
start_y  in  W  start row, sampled with start_x
move_valid  out  1  move offered downstream
move_ready  in  1  downstream accepts move
move_dir  out  2  direction of offered move
pos_x  out  W  current column (position after last accepted move)
pos_y  out  W  current row
busy  out  1  high in LOAD or PLAY
done  out  1  high in DONE
err  out  2  00 none, 01 buffer overflow, 10 off-grid step; sticky until clear
clear  in  1  returns DONE/ERR to IDLE

Behaviour:
- Direction encoding (fixed, matches solver): 00 y-1, 01 x+1, 10 x-1, 11 y+1.
- Reset (async): state IDLE; write pointer wp=0; pos_x=pos_y=0; err=00; all strobes (in_ready, move_valid, busy, done) 0. Buffer contents undefined.
- Transfer occurs on in_valid&&in_ready (input side) or move_valid&&move_ready (output side).
- wp is a $clog2(DEPTH)+1 bit count of stored entries.
- States:
  - IDLE:
    - in_ready=1.
    - nil=1: latch start_x/start_y into pos; go DONE. nil has priority over a simultaneous in_valid.
    - Transfer: latch start coords into pos; buf[0]=in_dir; wp=1; go PLAY if in_last, else LOAD.
  - LOAD:
    - in_ready=1 while wp<DEPTH. Each transfer writes buf[wp], wp++.
    - Transfer with in_last: go PLAY.
    - wp==DEPTH: in_ready stays 1. An in_valid that cycle is consumed and dropped; set err=01; go ERR.
  - PLAY:
    - in_ready=0; move_valid=1; move_dir=buf[wp-1], registered and stable while stalled.
    - First move out is the last entry received.
    - Before the transfer, check the step:
      - x+1 with pos_x=2^W-1, x-1 with pos_x=0, y-1 with pos_y=0, or y+1 with pos_y=2^W-1 is off-grid.
      - Off-grid: move_valid drops the next cycle; pos unchanged; err=10; go ERR.
      - move_valid is asserted only for legal moves. The check is made on entry to each move slot, so no off-grid move is ever offered.
    - Legal transfer: pos updated the same edge (no wrap, no saturation needed); wp--.
    - wp reaching 0: go DONE.
  - DONE: done=1; pos holds goal coords; clear goes IDLE.
  - ERR: err held; move_valid=0; in_ready=0; clear goes IDLE and err returns to 00.
- Latency: first move_valid one cycle after the in_last transfer. Back-to-back moves with move_ready held 1 give 1 move/cycle. A path of N moves completes in N+1 cycles after in_last.
- move_valid never drops without a transfer, except on reset.
- clear in IDLE/LOAD/PLAY is ignored.
- rst mid-LOAD or mid-PLAY aborts immediately to reset values. A partially replayed path is lost.
- pos_x/pos_y change only at start latch or on a legal move transfer.

Test Plan:
- Start (2,2). Entries in order 01, 11, 01(last). Expect moves 01, 11, 01 with move_ready=1. pos (3,2), (3,3), (4,3). done=1 on the 4th cycle after last.
- Same path, move_ready toggled 1-0-0-1-1. move_dir stable during stalls; exactly 3 moves; final pos (4,3).
- nil pulse with start (5,7) -> DONE next cycle, pos (5,7), move_valid never asserted.
- DEPTH=16: 16 entries without last, then a 17th offered -> err=01, state ERR, no moves. clear -> IDLE, err=00.
- Start (0,1). Single entry 10 (x-1) with last -> move_valid stays 0, err=10, pos (0,1). Repeat with start (15,15), entry 11 -> err=10.
- Assert rst during PLAY after 1 of 3 moves -> pos (0,0), outputs at reset values. A new 1-entry path then replays correctly.
